// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-requester arbiter.
//   N_REQ       : number of request lines
//   IDX_W       : width of a requester index
//   arb_state_t : arbiter FSM states
//   enc_id      : index -> downstream grant ID (line 0 encodes to 3)
//   onehot      : index -> one-hot grant vector
package arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Downstream muxes expect line 0 (highest priority) to encode to 3.
    function automatic logic [IDX_W-1:0] enc_id(input logic [IDX_W-1:0] idx);
        return IDX_W'(N_REQ - 1) - idx;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection.
//   req     in  : request lines
//   rr_mode in  : 0 = fixed priority (lowest index wins), 1 = round-robin
//   ptr     in  : last granted index; round-robin searches ptr+1 .. ptr
//   winner  out : selected index (don't-care when any_req is 0)
//   any_req out : at least one request present
module arb_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic             rr_mode,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    logic [IDX_W-1:0] idx;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        winner  = '0;
        idx     = '0;
        any_req = |req;
        if (rr_mode) begin
            for (int k = int'(N_REQ); k >= 1; k--) begin
                idx = ptr + IDX_W'(k);
                if (req[idx]) winner = idx;
            end
        end else begin
            for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
                if (req[i]) winner = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/req_arbiter.sv
// Four-requester arbiter with hold-time limit in front of the shared datapath port.
//   clk       in  : rising-edge clock
//   rst       in  : asynchronous active-low reset
//   rr_mode   in  : 0 = fixed priority, 1 = round-robin (sampled when idle)
//   req       in  : level-sensitive request lines
//   done      in  : owner finished, releases the grant
//   gnt       out : one-hot grant, zero when idle
//   gnt_id    out : encoded owner (req[0]->3 ... req[3]->0), zero when idle
//   gnt_valid out : grant active
//   expire    out : one-cycle pulse with the grant drop when release is by timeout only
module req_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rr_mode,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_id,
    output logic             gnt_valid,
    output logic             expire
);

    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [IDX_W-1:0] winner;
    logic             any_req;
    logic             hold_at_max;
    logic             owner_req;

    arb_pick u_pick (
        .req     (req),
        .rr_mode (rr_mode),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    // ptr doubles as the owner index while in ARB_GRANT.
    assign owner_req   = req[ptr];
    assign hold_at_max = (hold_cnt == HOLD_W'(MAX_HOLD));

    // Arbitration FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ARB_IDLE;
            ptr       <= IDX_W'(N_REQ - 1);
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            expire    <= 1'b0;
        end else begin
            expire <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        state     <= ARB_GRANT;
                        ptr       <= winner;
                        hold_cnt  <= HOLD_W'(1);
                        gnt       <= onehot(winner);
                        gnt_id    <= enc_id(winner);
                        gnt_valid <= 1'b1;
                    end
                end
                ARB_GRANT: begin
                    if (!owner_req || done || hold_at_max) begin
                        state     <= ARB_IDLE;
                        hold_cnt  <= '0;
                        gnt       <= '0;
                        gnt_id    <= '0;
                        gnt_valid <= 1'b0;
                        expire    <= hold_at_max && !done && owner_req;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_req_arbiter.sv
// Directed, table-driven bench for req_arbiter (MAX_HOLD=4 main instance,
// MAX_HOLD=1 second instance).
module tb_req_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       rr_mode;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       expire;

    logic       rr_mode1;
    logic [3:0] req1;
    logic       done1;
    logic [3:0] gnt1;
    logic [1:0] gnt_id1;
    logic       gnt_valid1;
    logic       expire1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    req_arbiter #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .rr_mode   (rr_mode),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .expire    (expire)
    );

    req_arbiter #(.MAX_HOLD(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .rr_mode   (rr_mode1),
        .req       (req1),
        .done      (done1),
        .gnt       (gnt1),
        .gnt_id    (gnt_id1),
        .gnt_valid (gnt_valid1),
        .expire    (expire1)
    );

    typedef struct {
        logic [3:0] req;
        logic       rr;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic [3:0] g, input logic [1:0] id,
                           input logic v, input logic e);
        chk({nm, "_gnt"},    8'(gnt),       8'(g));
        chk({nm, "_id"},     8'(gnt_id),    8'(id));
        chk({nm, "_valid"},  8'(gnt_valid), 8'(v));
        chk({nm, "_expire"}, 8'(expire),    8'(e));
    endtask

    initial begin
        // Fixed priority
        vecs.push_back('{4'b1100, 1'b0, 1'b0, 4'b0100, 2'd1, 1'b0});
        vecs.push_back('{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0});
        vecs.push_back('{4'b1111, 1'b0, 1'b0, 4'b0001, 2'd3, 1'b0});
        vecs.push_back('{4'b1111, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0});
        vecs.push_back('{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0});
        // Timeout: 4 grant cycles, expire on drop, 1 idle cycle, regrant
        vecs.push_back('{4'b0001, 1'b0, 1'b0, 4'b0001, 2'd3, 1'b0});
        vecs.push_back('{4'b0001, 1'b0, 1'b0, 4'b0001, 2'd3, 1'b0});
        vecs.push_back('{4'b0001, 1'b0, 1'b0, 4'b0001, 2'd3, 1'b0});
        vecs.push_back('{4'b0001, 1'b0, 1'b0, 4'b0001, 2'd3, 1'b0});
        vecs.push_back('{4'b0001, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1});
        vecs.push_back('{4'b0001, 1'b0, 1'b0, 4'b0001, 2'd3, 1'b0});
        // Timeout coinciding with done: no expire
        vecs.push_back('{4'b0001, 1'b0, 1'b0, 4'b0001, 2'd3, 1'b0});
        vecs.push_back('{4'b0001, 1'b0, 1'b0, 4'b0001, 2'd3, 1'b0});
        vecs.push_back('{4'b0001, 1'b0, 1'b0, 4'b0001, 2'd3, 1'b0});
        vecs.push_back('{4'b0001, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0});
        vecs.push_back('{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0});
        // Park ptr on line 3 so round-robin starts at line 0
        vecs.push_back('{4'b1000, 1'b0, 1'b0, 4'b1000, 2'd0, 1'b0});
        vecs.push_back('{4'b1000, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0});
        // Round-robin, done on each grant's first cycle
        vecs.push_back('{4'b1111, 1'b1, 1'b0, 4'b0001, 2'd3, 1'b0});
        vecs.push_back('{4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0});
        vecs.push_back('{4'b1111, 1'b1, 1'b0, 4'b0010, 2'd2, 1'b0});
        vecs.push_back('{4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0});
        vecs.push_back('{4'b1111, 1'b1, 1'b0, 4'b0100, 2'd1, 1'b0});
        vecs.push_back('{4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0});
        vecs.push_back('{4'b1111, 1'b1, 1'b0, 4'b1000, 2'd0, 1'b0});
        vecs.push_back('{4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0});
        vecs.push_back('{4'b1111, 1'b1, 1'b0, 4'b0001, 2'd3, 1'b0});
        // rr_mode flip mid-grant is ignored; done then releases
        vecs.push_back('{4'b1111, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0});
        // Owner drop with req[3] toggling during the grant
        vecs.push_back('{4'b0010, 1'b0, 1'b0, 4'b0010, 2'd2, 1'b0});
        vecs.push_back('{4'b1010, 1'b0, 1'b0, 4'b0010, 2'd2, 1'b0});
        vecs.push_back('{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0});

        rst = 1'b0; req = 4'b1111; rr_mode = 1'b0; done = 1'b0;
        req1 = 4'b0000; rr_mode1 = 1'b0; done1 = 1'b0;

        // Reset held with all requests active
        tick();
        tick();
        chk_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        rst = 1'b1;
        req = 4'b0000;
        tick();
        chk_all("post_reset_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            req     = vecs[i].req;
            rr_mode = vecs[i].rr;
            done    = vecs[i].done;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id,
                    |vecs[i].gnt, vecs[i].exp);
        end
        done = 1'b0;
        rr_mode = 1'b0;

        // Long idle stretch
        req = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("idle%0d_valid", c), 8'(gnt_valid), 8'd0);
            chk($sformatf("idle%0d_gnt", c),   8'(gnt),       8'd0);
        end

        // Asynchronous reset in the middle of a grant
        req = 4'b0100;
        tick();
        chk_all("pre_async_rst", 4'b0100, 2'd1, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk_all("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b0000;
        #2 rst = 1'b1;
        tick();
        chk_all("after_async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);

        // MAX_HOLD=1: alternating grant/idle, expire on every drop
        req1 = 4'b0001;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c % 2 == 0) begin
                chk($sformatf("mh1_%0d_gnt", c),    8'(gnt1),    8'h01);
                chk($sformatf("mh1_%0d_id", c),     8'(gnt_id1), 8'd3);
                chk($sformatf("mh1_%0d_expire", c), 8'(expire1), 8'd0);
            end else begin
                chk($sformatf("mh1_%0d_gnt", c),    8'(gnt1),    8'h00);
                chk($sformatf("mh1_%0d_id", c),     8'(gnt_id1), 8'd0);
                chk($sformatf("mh1_%0d_expire", c), 8'(expire1), 8'd1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/req_arbiter.md
# req_arbiter

Four-requester arbiter that shares one downstream resource between requesters. It picks one winner by either fixed priority or round-robin, then holds the grant until the owner releases it or a hold-time limit expires. It sits in front of the shared datapath port. The encoded grant ID uses the team's existing priority-encoding convention (line 0 is highest priority and encodes to 3), so downstream muxes decode it unchanged.

## Interface
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant; legal range 1..255
- HOLD_W, $clog2(MAX_HOLD+1), hold counter width; derived, never overridden
- clk  in  1  rising-edge clock
- rst  in  1  reset: asynchronous, active-low
- rr_mode  in  1  0 = fixed priority, 1 = round-robin; sampled only in ARB_IDLE
- req  in  4  request lines, level-sensitive, held until served
- done  in  1  owner finished; releases the current grant
- gnt  out  4  one-hot grant, all zero when idle
- gnt_id  out  2  encoded owner: req[0]->3, req[1]->2, req[2]->1, req[3]->0; 0 when idle
- gnt_valid  out  1  high while any grant is active
- expire  out  1  one-cycle pulse, asserted together with grant drop when the release is caused only by timeout

## Operation
- FSM states: ARB_IDLE and ARB_GRANT.
- ARB_IDLE:
  - If req==0, stay in ARB_IDLE.
  - Otherwise register the winner: gnt, gnt_id, gnt_valid=1, hold_cnt=1, ptr=winner index. Go to ARB_GRANT.
- Fixed priority: lowest index wins (req[0] highest).
- Round-robin:
  - Search order is ptr+1, ptr+2, ptr+3, ptr, modulo 4.
  - ptr resets to 3, so the first search equals fixed priority.
  - ptr also updates on fixed-mode grants.
- ARB_GRANT release condition: req[owner]==0, or done==1, or hold_cnt==MAX_HOLD.
  - On release, clear gnt, gnt_id and gnt_valid, and go to ARB_IDLE.
  - Otherwise increment hold_cnt.
- expire=1 only when hold_cnt==MAX_HOLD and done==0 and req[owner]==1. Otherwise expire=0.
- There is always one idle cycle between owners (gnt==0). Re-arbitration happens in that idle cycle.
- Changes to rr_mode, or to non-owner req lines, during ARB_GRANT do not affect the current grant.
- MAX_HOLD=1 gives exactly one grant cycle per arbitration.

## Timing
- All outputs are registered.
- Reset value of every output is 0. Reset also sets state=ARB_IDLE, ptr=3, hold_cnt=0.
- rst low mid-grant clears outputs immediately (asynchronously).
- After rst rises, the first arbitration occurs at the first posedge that samples req!=0.
- Grant latency: req sampled at posedge N in ARB_IDLE gives gnt valid after edge N, i.e. 1 cycle.
- Release latency: the release condition sampled at posedge M gives gnt==0 after edge M.
- Maximum grant duration: MAX_HOLD cycles.
- Worst-case wait for a continuously requesting line in round-robin: 3*(MAX_HOLD+1) cycles.
- gnt is always one-hot or zero; gnt_id is consistent with gnt every cycle.

## Structure
- Package arb_pkg holds:
  - localparam N_REQ=4
  - typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t
  - function enc_id(idx) returning 3-idx
- One sub-module, arb_pick, is purely combinational. Inputs: req, rr_mode, ptr. Outputs: winner index, any_req.
- req_arbiter holds the FSM, ptr, hold_cnt and the output registers.

## Test plan
All scenarios use MAX_HOLD=4 unless stated otherwise.
- Reset:
  - Hold rst=0 with req=1111 -> gnt=0000, gnt_id=0, gnt_valid=0, expire=0.
  - Drop rst mid-grant -> outputs clear before the next clock edge.
- Fixed priority:
  - rr_mode=0, req=1100 -> one cycle later gnt=0100, gnt_id=1.
  - After release, req=1111 -> gnt=0001, gnt_id=3.
- Timeout:
  - rr_mode=0, req=0001 held -> gnt=0001 for exactly 4 cycles.
  - expire=1 in the cycle gnt drops, then 1 idle cycle, then gnt=0001 again.
  - Repeat with done=1 on cycle 4 -> expire=0.
- Round-robin:
  - rr_mode=1, req=1111 held, done pulsed on each grant's first cycle -> grant sequence 0001, 0010, 0100, 1000, 0001, each separated by one idle cycle.
- Owner drop:
  - req=0010 for 2 cycles, then 0000 -> gnt=0010 for 2 cycles, drops after req falls, expire=0.
  - Toggling req[3] during the grant has no effect on the current grant.
- Idle:
  - req=0000 for 10 cycles -> gnt_valid stays 0 and the FSM stays in ARB_IDLE.
  - MAX_HOLD=1, req=0001 held -> grant pulses 1 cycle on, 1 cycle off, with expire=1 on each drop.
